rr_sel_arbiter3: RTL and testbench



---
 rtl/rr_sel_arbiter3.sv | 124 ++++++++++++
 tb/tb_rr_sel_arbiter3.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter3.sv
// rr_sel_arbiter3: three-requester round-robin arbiter with hold limit, driving sel0/sel1
// of a downstream 2:1-mux-tree three-input mux. Revision: 1.0
`default_nettype none

module rr_sel_arbiter3 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] gnt,
    output logic       busy,
    output logic       sel0,
    output logic       sel1,
    output logic       timeout
);

    localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       owner_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [2:0]       gnt_q;
    logic             busy_q;
    logic             sel0_q;
    logic             sel1_q;
    logic             timeout_q;

    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] pick_idx;
    logic       owner_req;
    logic       at_last;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Rotating priority scan: ptr first, then ptr+1, ptr+2 (mod 3).
    always_comb begin
        cand0    = ptr_q;
        cand1    = inc3(ptr_q);
        cand2    = inc3(cand1);
        pick_idx = cand2;
        if (req[cand0]) begin
            pick_idx = cand0;
        end else if (req[cand1]) begin
            pick_idx = cand1;
        end
    end

    always_comb begin
        owner_req = 1'b0;
        case (owner_q)
            2'd0:    owner_req = req[0];
            2'd1:    owner_req = req[1];
            2'd2:    owner_req = req[2];
            default: owner_req = 1'b0;
        endcase
        at_last = (hold_cnt_q == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            owner_q    <= 2'd0;
            hold_cnt_q <= '0;
            gnt_q      <= 3'b000;
            busy_q     <= 1'b0;
            sel0_q     <= 1'b0;
            sel1_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 3'b000) begin
                        state_q    <= GRANT;
                        owner_q    <= pick_idx;
                        hold_cnt_q <= '0;
                        gnt_q      <= 3'b001 << pick_idx;
                        busy_q     <= 1'b1;
                        sel0_q     <= (pick_idx == 2'd2);
                        sel1_q     <= (pick_idx == 2'd1);
                    end
                end
                GRANT: begin
                    if (done || !owner_req || at_last) begin
                        state_q   <= IDLE;
                        ptr_q     <= inc3(owner_q);
                        gnt_q     <= 3'b000;
                        busy_q    <= 1'b0;
                        sel0_q    <= 1'b0;
                        sel1_q    <= 1'b0;
                        // done and a dropped request outrank the hold limit
                        timeout_q <= !done && owner_req;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign sel0    = sel0_q;
    assign sel1    = sel1_q;
    assign timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_sel_arbiter3.sv
// tb_rr_sel_arbiter3: directed bench for rr_sel_arbiter3 (HOLD_MAX=4) with a behavioural mux on sel0/sel1.
`default_nettype none

module tb_rr_sel_arbiter3;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic       busy;
    logic       sel0;
    logic       sel1;
    logic       timeout;

    // Mux data inputs: i2,i1,i0 = 1,0,1
    logic i0;
    logic i1;
    logic i2;
    logic y;

    int tests;
    int fails;

    rr_sel_arbiter3 #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .busy    (busy),
        .sel0    (sel0),
        .sel1    (sel1),
        .timeout (timeout)
    );

    assign y = sel0 ? i2 : (sel1 ? i1 : i0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {gnt, busy, sel0, sel1, timeout}
    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {gnt, busy, sel0, sel1, timeout};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed gnt/busy/sel0/sel1/to=%b required=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_y(input string tag, input logic exp);
        tests++;
        assert (y === exp) else begin
            fails++;
            $error("FAIL %s observed y=%b required=%b", tag, y, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] IDLE_O = 7'b000_0_0_0_0;
    localparam logic [6:0] IDLE_T = 7'b000_0_0_0_1;
    localparam logic [6:0] G0     = 7'b001_1_0_0_0;
    localparam logic [6:0] G1     = 7'b010_1_0_1_0;
    localparam logic [6:0] G2     = 7'b100_1_1_0_0;

    initial begin
        tests = 0;
        fails = 0;
        i0 = 1'b1; i1 = 1'b0; i2 = 1'b1;
        rst_n = 1'b0; req = 3'b000; done = 1'b0;
        #12;
        chk("reset_state", IDLE_O);
        chk_y("reset_y_i0", 1'b1);
        tick();
        rst_n = 1'b1;

        // Round robin with done pulsed each grant
        req = 3'b111;
        tick(); chk("rr_g0", G0); chk_y("y_owner0", 1'b1);
        done = 1'b1;
        tick(); chk("rr_idle0", IDLE_O); chk_y("y_idle", 1'b1);
        done = 1'b0;
        tick(); chk("rr_g1", G1); chk_y("y_owner1", 1'b0);
        done = 1'b1;
        tick(); chk("rr_idle1", IDLE_O);
        done = 1'b0;
        tick(); chk("rr_g2", G2); chk_y("y_owner2", 1'b1);
        done = 1'b1;
        tick(); chk("rr_idle2", IDLE_O);
        done = 1'b0;
        tick(); chk("rr_wrap_g0", G0);
        done = 1'b1; req = 3'b000;
        tick(); chk("rr_end_idle", IDLE_O);
        done = 1'b0;
        tick(); chk("idle_no_req", IDLE_O);

        // Hold limit: ptr=1, only req0, 4-cycle grant then timeout
        req = 3'b001;
        tick(); chk("to_hold_c1", G0);
        tick(); chk("to_hold_c2", G0);
        tick(); chk("to_hold_c3", G0);
        tick(); chk("to_hold_c4", G0);
        tick(); chk("to_release", IDLE_T);
        tick(); chk("to_regrant", G0);
        req = 3'b000;
        tick(); chk("drop_release_no_to", IDLE_O);

        // Owner 1 drops request after 2 cycles; ptr moves to 2
        req = 3'b010;
        tick(); chk("drop_g1_c1", G1);
        tick(); chk("drop_g1_c2", G1);
        req = 3'b000;
        tick(); chk("drop_g1_release", IDLE_O);
        req = 3'b101;
        tick(); chk("ptr2_picks_2", G2);
        done = 1'b1;
        tick(); chk("ptr2_release", IDLE_O);
        done = 1'b0; req = 3'b000;

        // done coincides with final hold cycle: no timeout
        req = 3'b001;
        tick(); chk("coinc_c1", G0);
        tick(); tick(); tick(); chk("coinc_c4", G0);
        done = 1'b1;
        tick(); chk("coinc_release_no_to", IDLE_O);
        done = 1'b0;

        // ptr=1: req=100 grants 2; reset mid-grant clears asynchronously
        req = 3'b100;
        tick(); chk("pre_reset_g2", G2);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_clear", IDLE_O);
        chk_y("async_reset_y", 1'b1);
        req = 3'b111;
        tick();
        rst_n = 1'b1;
        tick(); chk("post_reset_ptr0", G0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
